// File: rtl/parity_check_arbiter.sv
// parity_check_arbiter
// Two byte sources share one even-parity check stage. A round-robin arbiter
// grants one requester at a time and returns a one-cycle response to it.
// Each requester has a saturating error counter for link-quality monitoring.
// A byte is correct when its parity bit equals the XOR of its data bits.

module parity_check_arbiter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   input  logic [7:0]       req0_data,
   input  logic             req0_parity,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [7:0]       req1_data,
   input  logic             req1_parity,
   output logic             req1_ready,
   output logic             rsp0_valid,
   output logic             rsp0_error,
   output logic             rsp1_valid,
   output logic             rsp1_error,
   output logic [CNT_W-1:0] err_cnt0,
   output logic [CNT_W-1:0] err_cnt1,
   input  logic             clr_cnt,
   output logic             busy,
   output logic             last_grant
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      RESP  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
   localparam logic [CNT_W-1:0] CntMax = '1;

   state_t           state_q;
   logic             lastGrant_q;
   logic [7:0]       data_q;
   logic             parity_q;
   logic             idx_q;
   logic             err_q;
   logic             rsp0Valid_q;
   logic             rsp1Valid_q;
   logic             rsp0Error_q;
   logic             rsp1Error_q;
   logic [CNT_W-1:0] errCnt0_q;
   logic [CNT_W-1:0] errCnt1_q;

   logic             sel;
   logic             grant0;
   logic             grant1;
   logic             handshake;
   logic             checkErr;

   // Round-robin selection: a lone valid requester wins outright, otherwise
   // the requester that was not granted last time goes next.
   always_comb begin
      sel = 1'b0;
      if (req0_valid && req1_valid) begin
         sel = ~lastGrant_q;
      end else begin
         sel = req1_valid;
      end
      grant0    = (state_q == IDLE) && req0_valid && !sel;
      grant1    = (state_q == IDLE) && req1_valid && sel;
      handshake = grant0 || grant1;
      checkErr  = (^data_q) ^ parity_q;
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;
   assign rsp0_valid = rsp0Valid_q;
   assign rsp1_valid = rsp1Valid_q;
   assign rsp0_error = rsp0Error_q;
   assign rsp1_error = rsp1Error_q;
   assign err_cnt0   = errCnt0_q;
   assign err_cnt1   = errCnt1_q;
   assign busy       = (state_q != IDLE);
   assign last_grant = lastGrant_q;

   // Transaction sequencer: capture on handshake, check, then pulse the
   // response for the captured requester; reset discards anything in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         lastGrant_q <= 1'b1;
         data_q      <= 8'h00;
         parity_q    <= 1'b0;
         idx_q       <= 1'b0;
         err_q       <= 1'b0;
         rsp0Valid_q <= 1'b0;
         rsp1Valid_q <= 1'b0;
         rsp0Error_q <= 1'b0;
         rsp1Error_q <= 1'b0;
      end else begin
         rsp0Valid_q <= 1'b0;
         rsp1Valid_q <= 1'b0;
         rsp0Error_q <= 1'b0;
         rsp1Error_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (handshake) begin
                  data_q      <= sel ? req1_data : req0_data;
                  parity_q    <= sel ? req1_parity : req0_parity;
                  idx_q       <= sel;
                  lastGrant_q <= sel;
                  state_q     <= CHECK;
               end
            end
            CHECK: begin
               err_q       <= checkErr;
               rsp0Valid_q <= !idx_q;
               rsp1Valid_q <= idx_q;
               rsp0Error_q <= !idx_q && checkErr;
               rsp1Error_q <= idx_q && checkErr;
               state_q     <= RESP;
            end
            RESP: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Saturating per-requester error counters; a clear wins over an increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         errCnt0_q <= '0;
         errCnt1_q <= '0;
      end else if (clr_cnt) begin
         errCnt0_q <= '0;
         errCnt1_q <= '0;
      end else if ((state_q == RESP) && err_q) begin
         if (!idx_q && (errCnt0_q != CntMax)) begin
            errCnt0_q <= errCnt0_q + CntOne;
         end
         if (idx_q && (errCnt1_q != CntMax)) begin
            errCnt1_q <= errCnt1_q + CntOne;
         end
      end
   end

endmodule
